// File: rtl/led_pkg.sv
// Shared constants for the LED range counter and LED display block.
// Holds the default bus width, the bar length and the counter FSM state encodings.
package led_pkg;

  localparam int LED_WIDTH     = 5;
  localparam int LED_MAX_COUNT = 16;

  typedef logic [1:0] led_state_t;

  localparam led_state_t ST_IDLE     = 2'd0;
  localparam led_state_t ST_RUN_UP   = 2'd1;
  localparam led_state_t ST_RUN_DOWN = 2'd2;

endpackage

// File: rtl/led_range_norm.sv
// Clamps both range bounds to the bar length and orders them into lo/hi.
module led_range_norm
  import led_pkg::*;
#(
  parameter int WIDTH     = LED_WIDTH,
  parameter int MAX_COUNT = LED_MAX_COUNT
) (
  input  logic [WIDTH-1:0] start_num,
  input  logic [WIDTH-1:0] end_num,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] start_c;
  logic [WIDTH-1:0] end_c;

  assign start_c = (start_num > MAX_V) ? MAX_V : start_num;
  assign end_c   = (end_num   > MAX_V) ? MAX_V : end_num;
  assign lo      = (start_c < end_c) ? start_c : end_c;
  assign hi      = (start_c < end_c) ? end_c   : start_c;

endmodule

// File: rtl/led_range_counter.sv
// Range counter driving the LED bar: counts between latched lo/hi bounds,
// wrapping or bouncing at the ends, with a one-cycle terminal pulse on check.
//
// state       | meaning
// ST_IDLE     | waiting for the first accepted tick to latch the range
// ST_RUN_UP   | counting toward hi
// ST_RUN_DOWN | counting toward lo
module led_range_counter
  import led_pkg::*;
#(
  parameter int WIDTH     = LED_WIDTH,
  parameter int MAX_COUNT = LED_MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] start_num,
  input  logic [WIDTH-1:0] end_num,
  input  logic             up_down,
  input  logic             mode,
  input  logic             hold,
  input  logic             restart,
  output logic [WIDTH-1:0] counter_out,
  output logic             check,
  output logic             dir_out
);

  led_state_t       state, state_n;
  logic [WIDTH-1:0] lo_r, hi_r, lo_n, hi_n;
  logic [WIDTH-1:0] count_n;
  logic             check_n;
  logic             go_up;
  logic [WIDTH-1:0] norm_lo, norm_hi;

  led_range_norm #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_norm (
    .start_num (start_num),
    .end_num   (end_num),
    .lo        (norm_lo),
    .hi        (norm_hi)
  );

  always_comb begin
    state_n = state;
    count_n = counter_out;
    lo_n    = lo_r;
    hi_n    = hi_r;
    check_n = 1'b0;
    go_up   = 1'b0;
    if (restart) begin
      state_n = ST_IDLE;
    end else if (tick && !hold) begin
      case (state)
        ST_IDLE: begin
          lo_n = norm_lo;
          hi_n = norm_hi;
          if (up_down) begin
            count_n = norm_lo;
            state_n = ST_RUN_UP;
          end else begin
            count_n = norm_hi;
            state_n = ST_RUN_DOWN;
          end
        end
        ST_RUN_UP, ST_RUN_DOWN: begin
          // wrap mode follows up_down live; bounce mode keeps its own direction
          go_up = mode ? (state == ST_RUN_UP) : up_down;
          if (go_up) begin
            state_n = ST_RUN_UP;
            if (counter_out < hi_r) begin
              count_n = counter_out + 1'b1;
            end else if (!mode) begin
              count_n = lo_r;
            end else begin
              state_n = ST_RUN_DOWN;
              count_n = (hi_r == lo_r) ? counter_out : hi_r - 1'b1;
            end
          end else begin
            state_n = ST_RUN_DOWN;
            if (counter_out > lo_r) begin
              count_n = counter_out - 1'b1;
            end else if (!mode) begin
              count_n = hi_r;
            end else begin
              state_n = ST_RUN_UP;
              count_n = (hi_r == lo_r) ? counter_out : lo_r + 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
      check_n = ((state_n == ST_RUN_UP)   && (count_n == hi_n)) ||
                ((state_n == ST_RUN_DOWN) && (count_n == lo_n));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      counter_out <= '0;
      check       <= 1'b0;
      lo_r        <= '0;
      hi_r        <= '0;
    end else begin
      state       <= state_n;
      counter_out <= count_n;
      check       <= check_n;
      lo_r        <= lo_n;
      hi_r        <= hi_n;
    end
  end

  assign dir_out = (state == ST_RUN_UP)   ? 1'b1 :
                   (state == ST_RUN_DOWN) ? 1'b0 : up_down;

endmodule

// File: doc/led_range_counter.md
LED_RANGE_COUNTER -- requirements
Module: led_range_counter

Interface
REQ-001 Parameter WIDTH, default 5: counter and range bus width.
REQ-002 Parameter MAX_COUNT, default 16: highest legal count, equal to the LED bar length.
REQ-003 Port clk, input, 1: single clock; the block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port tick, input, 1: one-clk step enable from the clock divider.
REQ-006 Port start_num, input, WIDTH: range start value.
REQ-007 Port end_num, input, WIDTH: range end value.
REQ-008 Port up_down, input, 1: direction select, 1 = up, 0 = down.
REQ-009 Port mode, input, 1: 0 = wrap, 1 = bounce.
REQ-010 Port hold, input, 1: pause; while high, tick is ignored.
REQ-011 Port restart, input, 1: reload the range and start position.
REQ-012 Port counter_out, output, WIDTH: current count, consumed by the LED bar decoder.
REQ-013 Port check, output, 1: one-cycle terminal-reached pulse.
REQ-014 Port dir_out, output, 1: current direction, 1 = up.

Function
REQ-015 Range normalise: each of start_num and end_num SHALL be clamped to MAX_COUNT; lo = min and hi = max of the clamped pair.
REQ-016 FSM states SHALL be IDLE, RUN_UP and RUN_DOWN.
REQ-017 IDLE SHALL be left on the first clk with tick=1 and hold=0.
  - That edge latches lo and hi into range registers.
  - counter_out is loaded with lo if up_down=1, hi if up_down=0.
  - The FSM enters RUN_UP or RUN_DOWN accordingly.
REQ-018 RUN_UP, on a tick with hold=0 and counter_out<hi: counter_out SHALL increment by 1.
REQ-019 RUN_UP, on a tick with counter_out==hi:
  - mode=0: counter_out <= lo.
  - mode=1: counter_out <= hi-1 and the FSM enters RUN_DOWN.
  - mode=1 with hi==lo: counter_out holds and the FSM enters RUN_DOWN.
REQ-020 RUN_DOWN SHALL mirror REQ-018 and REQ-019: decrement while counter_out>lo; at lo, wrap to hi (mode=0) or bounce to lo+1 and enter RUN_UP (mode=1).
REQ-021 In mode=0, up_down SHALL be sampled on every accepted tick.
  - A change of up_down switches state and steps in the new direction on that same tick.
  - In mode=1, up_down only selects the initial direction.
REQ-022 Latency: counter_out SHALL change exactly one clk edge after a sampled tick; with no accepted tick, counter_out is unchanged.
REQ-023 check SHALL be registered and high for exactly one clk cycle, on the edge where counter_out is loaded with the terminal value (hi in RUN_UP, lo in RUN_DOWN).
REQ-024 When lo==hi, check SHALL pulse on every accepted tick.
REQ-025 start_num and end_num changes while running SHALL be ignored until a restart.
REQ-026 restart=1 SHALL return the FSM to IDLE on the next edge, with counter_out holding its value and check=0; restart has priority over tick.
REQ-027 Input priority SHALL be rst > restart > hold > tick.
REQ-028 dir_out SHALL be 1 in RUN_UP, 0 in RUN_DOWN, and equal to up_down in IDLE.
REQ-029 counter_out SHALL never exceed MAX_COUNT and never leave [lo,hi] outside IDLE.

Reset
REQ-030 On any clk edge with rst=1, the block SHALL set counter_out=0, check=0, FSM=IDLE, lo=0 and hi=0.
REQ-031 rst asserted mid-run SHALL abort the run with no check pulse on that edge.

Structure
REQ-032 WIDTH, MAX_COUNT and the FSM state encodings SHALL be defined in shared package led_pkg, which is also used by the LED display block.
REQ-033 Clamp and min/max logic SHALL be one combinational sub-module, led_range_norm.
REQ-034 The FSM, count register and check register SHALL live in led_range_counter.

Verification
REQ-035 Wrap up: start=3, end=6, up_down=1, mode=0, 8 ticks -> counter_out 3,4,5,6,3,4,5,6; check high at each load of 6.
REQ-036 Bounce with swapped bounds: start=10, end=7, up_down=1, mode=1, 7 ticks -> counter_out 7,8,9,10,9,8,7; check pulses at 10 and at 7.
REQ-037 Clamp and degenerate range: start=20, end=31 -> lo=hi=16; every tick gives counter_out=16 with check pulsing each tick.
REQ-038 Hold and simultaneous events: hold=1 with tick -> no change; restart=1 with tick in the same cycle -> IDLE, counter_out unchanged, check=0.
REQ-039 Mid-run direction flip: mode=0 at count 5 in range 2..9, up_down 1->0 on a tick -> counter_out=4, dir_out=0.
REQ-040 Reset mid-run: rst=1 at counter_out=8 -> counter_out=0, check=0, IDLE; the next tick reloads from start.
